// File: rtl/instr_mem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
// The CHECK state is only reached when LOADER_CHECKSUM_EN is defined.
package instr_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WRITE,
    CHECK,
    DONE
  } loader_state_t;

  localparam int WORD_BYTES      = 4;
  localparam int WORD_ADDR_SHIFT = 2;

  function automatic logic [31:0] word_addr(input logic [31:0] idx);
    return idx << WORD_ADDR_SHIFT;
  endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// Bundle of the byte-stream handshake, memory write port and status lines.
// The master side feeds bytes; the slave side is the loader itself.
interface instr_mem_loader_if #(
  parameter int LEN_W = 8
);

  logic             start;
  logic [LEN_W-1:0] len_words;
  logic [7:0]       byte_data;
  logic             byte_valid;
  logic             byte_ready;
  logic             wr_en;
  logic [31:0]      wr_addr;
  logic [31:0]      wr_data;
  logic             busy;
  logic             done;
  logic             err;
  logic             cpu_hold;

  modport master (
    output start, len_words, byte_data, byte_valid,
    input  byte_ready, wr_en, wr_addr, wr_data, busy, done, err, cpu_hold
  );

  modport slave (
    input  start, len_words, byte_data, byte_valid,
    output byte_ready, wr_en, wr_addr, wr_data, busy, done, err, cpu_hold
  );

endinterface

// File: rtl/instr_mem_loader_word_packer.sv
// Packs incoming bytes little-endian into a 32-bit word; byte 0 ends up in
// bits [7:0] after four shifts. word_full_o flags the fourth accepted byte.
module instr_word_packer
  import instr_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        shift_en_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_full_o
);

  logic [31:0] word_q, word_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      word_q     <= '0;
      byte_cnt_q <= '0;
    end else begin
      word_q     <= word_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  // Shifting in from the top leaves the first byte in the lowest lane.
  always_comb begin
    word_d     = word_q;
    byte_cnt_d = byte_cnt_q;
    if (clr_i) begin
      word_d     = '0;
      byte_cnt_d = '0;
    end else if (shift_en_i) begin
      word_d     = {byte_i, word_q[31:8]};
      byte_cnt_d = byte_cnt_q + 2'd1;
    end
  end

  assign word_o      = word_q;
  assign word_full_o = shift_en_i && (byte_cnt_q == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/instr_mem_loader.sv
// Boot loader: streams bytes into instruction memory words and holds the CPU
// in reset until loading ends. Define LOADER_CHECKSUM_EN for a trailing check byte.
module instr_mem_loader
  import instr_loader_pkg::*;
#(
  parameter int DEPTH = 128,
  parameter int LEN_W = 8
) (
  input logic               clk_i,
  input logic               rst_i,
  instr_mem_loader_if.slave ldr_if
);

  loader_state_t    state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] word_idx_q, word_idx_d;
  logic             cpu_hold_q, cpu_hold_d;
  logic             err_q, err_d;
  logic [31:0]      word;
  logic             word_full;
  logic             xfer;
  logic             shift_en;
  logic             pack_clr;
  logic             len_ok;
  logic             last_word;

  assign xfer      = ldr_if.byte_valid && ldr_if.byte_ready;
  assign shift_en  = (state_q == LOAD) && xfer;
  assign pack_clr  = (state_q == IDLE) || (state_q == WRITE);
  assign len_ok    = (ldr_if.len_words != '0) && (int'(ldr_if.len_words) <= DEPTH);
  assign last_word = (word_idx_q + LEN_W'(1)) == len_q;

  instr_word_packer u_packer (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clr_i       (pack_clr),
    .shift_en_i  (shift_en),
    .byte_i      (ldr_if.byte_data),
    .word_o      (word),
    .word_full_o (word_full)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      len_q      <= '0;
      word_idx_q <= '0;
      cpu_hold_q <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
      cpu_hold_q <= cpu_hold_d;
      err_q      <= err_d;
    end
  end

  // cpu_hold drops on entry to DONE so it falls together with the done pulse.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    cpu_hold_d = cpu_hold_q;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (ldr_if.start) begin
          if (len_ok) begin
            len_d      = ldr_if.len_words;
            word_idx_d = '0;
            cpu_hold_d = 1'b1;
            state_d    = LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (word_full) state_d = WRITE;
      end
      WRITE: begin
        word_idx_d = word_idx_q + LEN_W'(1);
        if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
          state_d    = CHECK;
`else
          state_d    = DONE;
          cpu_hold_d = 1'b0;
`endif
        end else begin
          state_d = LOAD;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        if (xfer) begin
          state_d    = DONE;
          cpu_hold_d = 1'b0;
        end
      end
`endif
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic       chk_fail_q, chk_fail_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sum_q      <= '0;
      chk_fail_q <= 1'b0;
    end else begin
      sum_q      <= sum_d;
      chk_fail_q <= chk_fail_d;
    end
  end

  // Running 8-bit sum of data bytes; the check byte must bring it to zero.
  always_comb begin
    sum_d      = sum_q;
    chk_fail_d = chk_fail_q;
    if (state_q == IDLE) begin
      sum_d      = '0;
      chk_fail_d = 1'b0;
    end else if (shift_en) begin
      sum_d = sum_q + ldr_if.byte_data;
    end else if ((state_q == CHECK) && xfer) begin
      chk_fail_d = (sum_q + ldr_if.byte_data) != 8'd0;
    end
  end

  assign ldr_if.err = err_q || ((state_q == DONE) && chk_fail_q);
`else
  assign ldr_if.err = err_q;
`endif

  assign ldr_if.byte_ready = (state_q == LOAD) || (state_q == CHECK);
  assign ldr_if.busy       = (state_q == LOAD) || (state_q == WRITE) || (state_q == CHECK);
  assign ldr_if.wr_en      = (state_q == WRITE);
  assign ldr_if.wr_addr    = ldr_if.wr_en ? word_addr(32'(word_idx_q)) : '0;
  assign ldr_if.wr_data    = ldr_if.wr_en ? word : '0;
  assign ldr_if.done       = (state_q == DONE);
  assign ldr_if.cpu_hold   = cpu_hold_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomised self-checking bench for instr_mem_loader; expected memory writes
// and checksum outcome come from a byte-queue model. Honours LOADER_CHECKSUM_EN.
module tb_instr_mem_loader;

  localparam int DEPTH = 128;
  localparam int LEN_W = 8;

  typedef logic [7:0] byteQ_t[$];

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  instr_mem_loader_if #(.LEN_W(LEN_W)) bus ();

  instr_mem_loader #(
    .DEPTH (DEPTH),
    .LEN_W (LEN_W)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .ldr_if (bus)
  );

  int checkCount = 0;
  int errorCount = 0;
  int wrSeen     = 0;
  logic [31:0] expAddrQ[$];
  logic [31:0] expDataQ[$];

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
    end
  endtask

  function automatic logic [7:0] byteSum(input byteQ_t q);
    logic [7:0] s = 8'd0;
    foreach (q[i]) s = s + q[i];
    return s;
  endfunction

  // Every write strobe is matched against the model's queue of expected words.
  always @(negedge clk) begin
    if (!rst && bus.wr_en === 1'b1) begin
      wrSeen++;
      if (expAddrQ.size() == 0) begin
        checkOutput("unexpected_wr", 32'(bus.wr_en), 32'd0);
      end else begin
        checkOutput("wr_addr", bus.wr_addr, expAddrQ.pop_front());
        checkOutput("wr_data", bus.wr_data, expDataQ.pop_front());
      end
    end
  end

  task automatic startLoad(input int len);
    bus.len_words = LEN_W'(len);
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start     = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b, input bit gap);
    int n = 0;
    if (gap) begin
      bus.byte_valid = 1'b0;
      @(posedge clk); #1;
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    do begin
      @(negedge clk);
      n++;
    end while (bus.byte_ready !== 1'b1 && n < 50);
    if (bus.byte_ready !== 1'b1) checkOutput("ready_timeout", 32'(bus.byte_ready), 32'd1);
    @(posedge clk); #1;
    bus.byte_valid = 1'b0;
  endtask

  task automatic waitDone(input bit expErr);
    int n = 0;
    while (bus.done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("done_seen", 32'(bus.done), 32'd1);
    checkOutput("hold_at_done", 32'(bus.cpu_hold), 32'd0);
    checkOutput("err_at_done", 32'(bus.err), 32'(expErr));
    checkOutput("writes_left", 32'(expAddrQ.size()), 32'd0);
    @(negedge clk);
    checkOutput("done_one_cycle", 32'(bus.done), 32'd0);
    checkOutput("hold_after_done", 32'(bus.cpu_hold), 32'd0);
    @(posedge clk); #1;
  endtask

  // gapMode: 0 = back-to-back, 1 = idle cycle before every byte, 2 = random idles.
  task automatic applyStimulus(input int len, input byteQ_t bytes, input int gapMode,
                               input logic [7:0] checkByte, input bit pulseStart);
    bit expErr = 1'b0;
    for (int i = 0; i < len; i++) begin
      expAddrQ.push_back(32'(i * 4));
      expDataQ.push_back({bytes[4*i+3], bytes[4*i+2], bytes[4*i+1], bytes[4*i]});
    end
    startLoad(len);
    checkOutput("hold_on_start", 32'(bus.cpu_hold), 32'd1);
    checkOutput("busy_on_start", 32'(bus.busy), 32'd1);
    for (int k = 0; k < 4 * len; k++) begin
      if (pulseStart && k == 1) startLoad(5);
      sendByte(bytes[k], (gapMode == 1) ? 1'b1 : (gapMode == 2) ? 1'($urandom_range(0, 1)) : 1'b0);
    end
`ifdef LOADER_CHECKSUM_EN
    sendByte(checkByte, 1'b0);
    expErr = (byteSum(bytes) + checkByte) != 8'd0;
`else
    expErr = (checkByte != checkByte);
`endif
    waitDone(expErr);
  endtask

  task automatic rejectTest(input int len);
    int errCnt = 0, busyCnt = 0, doneCnt = 0, w0;
    logic holdBefore;
    holdBefore = bus.cpu_hold;
    w0 = wrSeen;
    startLoad(len);
    repeat (4) begin
      @(negedge clk);
      errCnt  += int'(bus.err);
      busyCnt += int'(bus.busy);
      doneCnt += int'(bus.done);
    end
    checkOutput("reject_err_pulses", 32'(errCnt), 32'd1);
    checkOutput("reject_busy", 32'(busyCnt), 32'd0);
    checkOutput("reject_done", 32'(doneCnt), 32'd0);
    checkOutput("reject_wr", 32'(wrSeen - w0), 32'd0);
    checkOutput("reject_hold", 32'(bus.cpu_hold), 32'(holdBefore));
    @(posedge clk); #1;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_hold"}, 32'(bus.cpu_hold), 32'd1);
    checkOutput({tag, "_ready"}, 32'(bus.byte_ready), 32'd0);
    checkOutput({tag, "_wr_en"}, 32'(bus.wr_en), 32'd0);
    checkOutput({tag, "_done"}, 32'(bus.done), 32'd0);
    checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd0);
    checkOutput({tag, "_err"}, 32'(bus.err), 32'd0);
    checkOutput({tag, "_wr_addr"}, bus.wr_addr, 32'd0);
    checkOutput({tag, "_wr_data"}, bus.wr_data, 32'd0);
  endtask

  initial begin
    byteQ_t b;
    int len, w0;
    logic [7:0] cb;

    bus.start      = 1'b0;
    bus.len_words  = '0;
    bus.byte_data  = '0;
    bus.byte_valid = 1'b0;
    rst            = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkIdle("in_reset");
    rst = 1'b0;
    @(posedge clk); #1;
    checkIdle("idle");

    b = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    cb = 8'h00 - byteSum(b);
    applyStimulus(2, b, 0, cb, 1'b0);
    applyStimulus(2, b, 1, cb, 1'b1);

    rejectTest(0);
    rejectTest(DEPTH + 1);

    // Reset in the middle of word 1 must abandon the partial word.
    b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    expAddrQ.push_back(32'h0);
    expDataQ.push_back(32'h44332211);
    startLoad(2);
    for (int k = 0; k < 6; k++) sendByte(b[k], 1'b0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_hold", 32'(bus.cpu_hold), 32'd1);
    checkOutput("rst_mid_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_mid_ready", 32'(bus.byte_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    w0 = wrSeen;
    repeat (8) @(negedge clk);
    checkOutput("rst_mid_no_wr", 32'(wrSeen - w0), 32'd0);
    checkOutput("rst_mid_hold2", 32'(bus.cpu_hold), 32'd1);
    @(posedge clk); #1;
    b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    cb = 8'h00 - byteSum(b);
    applyStimulus(1, b, 0, cb, 1'b0);

    for (int r = 0; r < 6; r++) begin
      len = $urandom_range(1, 6);
      b = {};
      repeat (4 * len) b.push_back(8'($urandom));
      cb = 8'h00 - byteSum(b);
      if (r % 2 == 1) cb = cb + 8'($urandom_range(1, 255));
      applyStimulus(len, b, 2, cb, r == 3);
    end

    b = {};
    repeat (4 * DEPTH) b.push_back(8'($urandom));
    cb = 8'h00 - byteSum(b);
    applyStimulus(DEPTH, b, 0, cb, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    b = '{8'h01, 8'h02, 8'h03, 8'h04};
    applyStimulus(1, b, 0, 8'hF6, 1'b0);
    applyStimulus(1, b, 0, 8'h00, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
